zest_bitslip_align: RTL and testbench
=====================================

ZEST_BITSLIP_ALIGN -- requirements
Module: zest_bitslip_align

Interface
REQ-001 The block SHALL have parameter LANES, default 8, meaning the number of AD9653 serial lanes handled (one U2 or U3 ADC).
REQ-002 The block SHALL have parameter SER_W, default 8, meaning deserialization width per lane and the maximum number of slips per lane.
REQ-003 The block SHALL have parameter RST_CYC, default 4, meaning the number of cycles iserdes_reset is held.
REQ-004 The block SHALL have parameter SETTLE, default 4, meaning the wait in cycles after any reset or bitslip before comparing.
REQ-005 The block SHALL have parameter MATCH_CNT, default 16, meaning the consecutive matching words required per check window.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, the divided ISERDES clock (clk_div_bufg).
REQ-007 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 The block SHALL have port start, input, 1 bit: single-cycle request to begin training.
REQ-009 The block SHALL have port pattern, input, SER_W bits: the expected training word (ADC test pattern).
REQ-010 The block SHALL have port dout, input, LANES*SER_W bits: deserialized data, with lane k occupying bits [k*SER_W +: SER_W].
REQ-011 The block SHALL have port iserdes_reset, output, 1 bit: reset to the ISERDES.
REQ-012 The block SHALL have port bitslip, output, LANES bits: per-lane single-cycle slip pulses.
REQ-013 The block SHALL have port busy, output, 1 bit: high while training is in progress.
REQ-014 The block SHALL have port done, output, 1 bit: level, high after training completes until the next start.
REQ-015 The block SHALL have port lane_ok, output, LANES bits: lane locked to pattern.
REQ-016 The block SHALL have port lane_fail, output, LANES bits: lane exhausted SER_W slips without a lock.
REQ-017 The block SHALL have port slip_cnt, output, LANES*4 bits: slips applied per lane.

Function
REQ-018 The FSM SHALL have states IDLE, RST, SETTLE, CHECK, SLIP and DONE.
REQ-019 On start in IDLE or DONE, the block SHALL capture pattern, clear lane_ok, lane_fail, slip_cnt and done, and enter RST on the next cycle.
REQ-020 start SHALL be ignored while busy.
REQ-021 In RST, iserdes_reset SHALL be high for exactly RST_CYC cycles, after which the FSM enters SETTLE.
REQ-022 SETTLE SHALL last exactly SETTLE cycles, with no comparison performed, and then enter CHECK.
REQ-023 CHECK SHALL last exactly MATCH_CNT cycles.
REQ-024 In CHECK, a lane SHALL pass only if its word equals the captured pattern on every cycle of the window.
REQ-025 At the end of CHECK, each passing lane not already failed SHALL set lane_ok, which stays set until the next start.
REQ-026 At the end of CHECK, each pending lane (not ok, not failed) with slip_cnt equal to SER_W SHALL set lane_fail.
REQ-027 After CHECK, if no pending lanes with slip_cnt below SER_W remain, the FSM SHALL enter DONE; otherwise it SHALL enter SLIP.
REQ-028 SLIP SHALL last one cycle, assert bitslip for exactly the pending lanes with slip_cnt below SER_W, increment those slip_cnt values, and then enter SETTLE.
REQ-029 bitslip SHALL be zero in every state except SLIP.
REQ-030 A locked lane SHALL never be slipped again within a run.
REQ-031 busy SHALL be high in RST, SETTLE, CHECK and SLIP.
REQ-032 done SHALL rise on entry to DONE, with lane_ok and lane_fail stable and lane_ok OR lane_fail equal to all ones.
REQ-033 slip_cnt SHALL saturate at SER_W and never wrap.
REQ-034 If a lane matches for part of a window then mismatches, it SHALL fail that window, with no partial credit carried across windows.
REQ-035 Worst-case duration SHALL be RST_CYC + (SER_W+1)*(SETTLE+MATCH_CNT) + SER_W cycles.

Reset
REQ-036 rst SHALL asynchronously force state IDLE and clear iserdes_reset, bitslip, busy, done, lane_ok, lane_fail, slip_cnt, all internal counters and the captured pattern.
REQ-037 Reset asserted mid-run SHALL abort the run, with no further bitslip pulses issued after rst rises.
REQ-038 Release of rst SHALL take effect synchronously.

Structure
REQ-039 Package zest_align_pkg SHALL hold the FSM state enum, the slip_cnt width constant (4) and the default parameter values.
REQ-040 Sub-module zest_bitslip_lane SHALL hold the per-lane compare flag, ok/fail flags and slip counter, and SHALL be instantiated LANES times.
REQ-041 The top level SHALL hold only the FSM, the phase counter and the pattern register.

Verification
REQ-042 With all lanes presenting 0xF0 and pattern 0xF0, start SHALL give iserdes_reset high for 4 cycles, no bitslip, done after 4+4+16 cycles, lane_ok 0xFF and slip_cnt all 0.
REQ-043 With lane 3 needing 5 rotations and others aligned, the bench SHALL see exactly 5 bitslip[3] pulses, lane_ok 0xFF, slip_cnt[3] 5 and all other slip_cnt values 0.
REQ-044 With lane 0 stuck at 0x00, the bench SHALL see 8 slips on lane 0, lane_fail 0x01, lane_ok 0xFE and done high.
REQ-045 With one glitch word on lane 2 during the first CHECK, lane 2 SHALL fail that window, slip once, and not pass the rotated word (unless the rotation matches).
REQ-046 With rst pulsed during SLIP of the 3rd iteration, all outputs SHALL read 0 in the same cycle and no bitslip SHALL occur after rst; a new start SHALL give a normal run.
REQ-047 With start pulsed while busy, the bench SHALL see no restart, no change in slip_cnt and the completion time per REQ-035.

Source files
------------

// File: rtl/zest_align_pkg.sv
// ============================================================================
// zest_align_pkg : shared types and defaults for the AD9653 bitslip aligner
// Rev 1.0
// ============================================================================
`default_nettype none

package zest_align_pkg;

    localparam int SLIP_W        = 4;
    localparam int DEF_LANES     = 8;
    localparam int DEF_SER_W     = 8;
    localparam int DEF_RST_CYC   = 4;
    localparam int DEF_SETTLE    = 4;
    localparam int DEF_MATCH_CNT = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RST    = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_SLIP   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/zest_bitslip_lane.sv
// ============================================================================
// zest_bitslip_lane : per-lane match tracking, lock/fail flags, slip counter
// Rev 1.0
// ============================================================================
`default_nettype none

module zest_bitslip_lane
    import zest_align_pkg::*;
#(
    parameter int SER_W = DEF_SER_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_check,
    input  logic              i_first,
    input  logic              i_last,
    input  logic              i_slip,
    input  logic [SER_W-1:0]  i_word,
    input  logic [SER_W-1:0]  i_pattern,
    output logic              o_ok,
    output logic              o_fail,
    output logic              o_bitslip,
    output logic              o_need,
    output logic [SLIP_W-1:0] o_slip_cnt
);

    logic              r_match;
    logic              r_ok;
    logic              r_fail;
    logic [SLIP_W-1:0] r_cnt;

    logic w_eq;
    logic w_pass;
    logic w_ok_next;
    logic w_below;

    assign w_eq      = (i_word == i_pattern);
    // The first window cycle restarts the running AND so no credit carries over
    assign w_pass    = w_eq & (i_first | r_match);
    assign w_ok_next = r_ok | (w_pass & ~r_fail);
    assign w_below   = (r_cnt < SLIP_W'(SER_W));

    assign o_need     = ~w_ok_next & ~r_fail & w_below;
    assign o_bitslip  = i_slip & ~r_ok & ~r_fail & w_below;
    assign o_ok       = r_ok;
    assign o_fail     = r_fail;
    assign o_slip_cnt = r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_match <= 1'b0;
            r_ok    <= 1'b0;
            r_fail  <= 1'b0;
            r_cnt   <= '0;
        end else if (i_clr) begin
            r_match <= 1'b0;
            r_ok    <= 1'b0;
            r_fail  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (i_check) begin
                r_match <= w_pass;
            end
            if (i_check && i_last) begin
                r_ok <= w_ok_next;
                if (!w_ok_next && !r_fail && !w_below) begin
                    r_fail <= 1'b1;
                end
            end
            if (o_bitslip) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/zest_bitslip_align.sv
// ============================================================================
// zest_bitslip_align : ISERDES reset + per-lane bitslip training sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module zest_bitslip_align
    import zest_align_pkg::*;
#(
    parameter int LANES     = DEF_LANES,
    parameter int SER_W     = DEF_SER_W,
    parameter int RST_CYC   = DEF_RST_CYC,
    parameter int SETTLE    = DEF_SETTLE,
    parameter int MATCH_CNT = DEF_MATCH_CNT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [SER_W-1:0]        pattern,
    input  logic [LANES*SER_W-1:0]  dout,
    output logic                    iserdes_reset,
    output logic [LANES-1:0]        bitslip,
    output logic                    busy,
    output logic                    done,
    output logic [LANES-1:0]        lane_ok,
    output logic [LANES-1:0]        lane_fail,
    output logic [LANES*SLIP_W-1:0] slip_cnt
);

    localparam int PH_MAX = max3(RST_CYC, SETTLE, MATCH_CNT);
    localparam int PH_W   = $clog2(PH_MAX + 1);

    state_t           r_state;
    logic [PH_W-1:0]  r_phase;
    logic [SER_W-1:0] r_pattern;

    logic             w_start_ok;
    logic             w_check;
    logic             w_slip;
    logic             w_first;
    logic             w_last;
    logic [LANES-1:0] w_need;

    assign w_start_ok = start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    assign w_check    = (r_state == ST_CHECK);
    assign w_slip     = (r_state == ST_SLIP);
    assign w_first    = (r_phase == '0);
    assign w_last     = (r_phase == PH_W'(MATCH_CNT - 1));

    // Decoded straight from the state register so an async reset clears them at once
    assign iserdes_reset = (r_state == ST_RST);
    assign busy          = (r_state == ST_RST) | (r_state == ST_SETTLE) | w_check | w_slip;
    assign done          = (r_state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_phase   <= '0;
            r_pattern <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_ok) begin
                        r_state   <= ST_RST;
                        r_phase   <= '0;
                        r_pattern <= pattern;
                    end
                end
                ST_RST: begin
                    if (r_phase == PH_W'(RST_CYC - 1)) begin
                        r_state <= ST_SETTLE;
                        r_phase <= '0;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (r_phase == PH_W'(SETTLE - 1)) begin
                        r_state <= ST_CHECK;
                        r_phase <= '0;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (w_last) begin
                        r_state <= (|w_need) ? ST_SLIP : ST_DONE;
                        r_phase <= '0;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                ST_SLIP: begin
                    r_state <= ST_SETTLE;
                    r_phase <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_phase <= '0;
                end
            endcase
        end
    end

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            zest_bitslip_lane #(
                .SER_W (SER_W)
            ) u_lane (
                .clk        (clk),
                .rst        (rst),
                .i_clr      (w_start_ok),
                .i_check    (w_check),
                .i_first    (w_first),
                .i_last     (w_last),
                .i_slip     (w_slip),
                .i_word     (dout[k*SER_W +: SER_W]),
                .i_pattern  (r_pattern),
                .o_ok       (lane_ok[k]),
                .o_fail     (lane_fail[k]),
                .o_bitslip  (bitslip[k]),
                .o_need     (w_need[k]),
                .o_slip_cnt (slip_cnt[k*SLIP_W +: SLIP_W])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_zest_bitslip_align.sv
// ============================================================================
// tb_zest_bitslip_align : directed scenarios with a rotating-lane ISERDES model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_zest_bitslip_align;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  pattern;
    logic [63:0] dout;
    logic        iserdes_reset;
    logic [7:0]  bitslip;
    logic        busy;
    logic        done;
    logic [7:0]  lane_ok;
    logic [7:0]  lane_fail;
    logic [31:0] slip_cnt;

    zest_bitslip_align #(
        .LANES     (8),
        .SER_W     (8),
        .RST_CYC   (4),
        .SETTLE    (4),
        .MATCH_CNT (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .pattern       (pattern),
        .dout          (dout),
        .iserdes_reset (iserdes_reset),
        .bitslip       (bitslip),
        .busy          (busy),
        .done          (done),
        .lane_ok       (lane_ok),
        .lane_fail     (lane_fail),
        .slip_cnt      (slip_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ok;
        logic [7:0]  fail;
        logic [31:0] slip;
        logic [31:0] pulses;
        int          busy_cyc;
        int          rst_cyc;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         failures = 0;
    int         n_done = 0;
    logic [7:0] base[8];
    int         nsl[8];
    bit         glitch_en = 1'b0;
    int         idx = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < (n % 8); i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic exp_t mk(input logic [7:0] ok, input logic [7:0] fl,
                                input logic [31:0] sc, input int bc);
        exp_t e;
        e.ok = ok; e.fail = fl; e.slip = sc; e.pulses = sc; e.busy_cyc = bc; e.rst_cyc = 4;
        return e;
    endfunction

    // ISERDES model: each slip rotates the lane word left by one bit
    always @(negedge clk) begin
        logic [7:0] w;
        for (int k = 0; k < 8; k++) begin
            if (iserdes_reset) nsl[k] = 0;
            else if (bitslip[k]) nsl[k] = nsl[k] + 1;
        end
        for (int k = 0; k < 8; k++) begin
            w = rotl(base[k], nsl[k]);
            if (glitch_en && k == 2 && busy && idx == 15) w = w ^ 8'h01;
            dout[k*8 +: 8] = w;
        end
        if (busy) idx = idx + 1;
        else idx = 0;
    end

    // Monitor: measure each run, compare on the rising edge of done
    logic        prev_busy = 1'b0;
    logic        prev_done = 1'b0;
    int          m_busy = 0;
    int          m_rst = 0;
    logic [31:0] m_pulse = '0;

    always @(negedge clk) begin
        exp_t e;
        if (busy && !prev_busy) begin
            m_busy = 0; m_rst = 0; m_pulse = '0;
        end
        if (busy) m_busy = m_busy + 1;
        if (iserdes_reset) m_rst = m_rst + 1;
        for (int k = 0; k < 8; k++)
            if (bitslip[k]) m_pulse[k*4 +: 4] = m_pulse[k*4 +: 4] + 4'd1;
        if (done && !prev_done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                chk("lane_ok",   64'(lane_ok),   64'(e.ok));
                chk("lane_fail", 64'(lane_fail), 64'(e.fail));
                chk("slip_cnt",  64'(slip_cnt),  64'(e.slip));
                chk("bitslip_pulses", 64'(m_pulse), 64'(e.pulses));
                chk("busy_cycles", 64'(m_busy), 64'(e.busy_cyc));
                chk("iserdes_reset_cycles", 64'(m_rst), 64'(e.rst_cyc));
            end
            n_done = n_done + 1;
        end
        prev_busy = busy;
        prev_done = done;
    end

    task automatic set_base(input logic [7:0] v);
        for (int k = 0; k < 8; k++) base[k] = v;
    endtask

    task automatic run_case(input logic [7:0] pat, input exp_t e, input bit gl, input int extra_at);
        int target;
        pattern   = pat;
        glitch_en = gl;
        q.push_back(e);
        target = n_done + 1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 1000 && n_done < target; c++) begin
            @(negedge clk);
            start = (c == extra_at);
        end
        start = 1'b0;
        glitch_en = 1'b0;
        if (n_done < target) begin
            chk("done_timeout", 64'd0, 64'd1);
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int seen;
        int late;
        rst = 1'b1; start = 1'b0; pattern = '0; dout = '0;
        for (int k = 0; k < 8; k++) nsl[k] = 0;
        set_base(8'h00);
        repeat (3) @(negedge clk);
        chk("reset_outputs", {5'd0, iserdes_reset, busy, done, bitslip, lane_ok, lane_fail, slip_cnt}, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // All lanes aligned to 0xF0
        set_base(8'hF0);
        run_case(8'hF0, mk(8'hFF, 8'h00, 32'h0, 24), 1'b0, -1);

        // Lane 3 needs five left rotations: rotl(0xE8,5) = 0x1D
        set_base(8'h1D); base[3] = 8'hE8;
        run_case(8'h1D, mk(8'hFF, 8'h00, 32'h0000_5000, 129), 1'b0, -1);

        // Lane 0 stuck at zero: exhausts all slips
        set_base(8'h1D); base[0] = 8'h00;
        run_case(8'h1D, mk(8'hFE, 8'h01, 32'h0000_0008, 192), 1'b0, -1);

        // Glitch on lane 2 in first window; only the 8th rotation matches again
        set_base(8'h1D);
        run_case(8'h1D, mk(8'hFF, 8'h00, 32'h0000_0800, 192), 1'b1, -1);

        // Start pulsed while busy must be ignored
        set_base(8'h1D); base[0] = 8'h00;
        run_case(8'h1D, mk(8'hFE, 8'h01, 32'h0000_0008, 192), 1'b0, 50);

        // Reset during the third SLIP
        set_base(8'h1D); base[0] = 8'h00;
        pattern = 8'h1D;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        seen = 0;
        for (int c = 0; c < 500 && seen < 3; c++) begin
            @(negedge clk);
            if (|bitslip) seen++;
        end
        chk("third_slip_seen", 64'(seen), 64'd3);
        #1 rst = 1'b1;
        #1 chk("abort_outputs", {5'd0, iserdes_reset, busy, done, bitslip, lane_ok, lane_fail, slip_cnt}, 64'd0);
        late = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c == 2) rst = 1'b0;
            if (|bitslip || busy) late++;
        end
        chk("no_activity_after_rst", 64'(late), 64'd0);

        set_base(8'h1D);
        run_case(8'h1D, mk(8'hFF, 8'h00, 32'h0, 24), 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
